// File: rtl/mmio_timer_if.sv
// CPU load/store bus as seen by a memory-mapped peripheral.
// The CPU is the master and drives the access; the peripheral answers combinationally.
interface mmio_timer_if;
  logic        WE;
  logic [2:0]  size;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        Sel;
  logic        Err;

  modport master (output WE, size, A, WD, input RD, Sel, Err);
  modport slave  (input WE, size, A, WD, output RD, Sel, Err);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with a compare register, a sticky MATCH flag and an IRQ.
// Reads are combinational so a single-cycle CPU finishes a load in the same cycle.
// Stores update only the addressed byte lanes and commit on the rising CLK edge.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic         CLK,
  input  logic         reset,
  mmio_timer_if.slave  bus,
  output logic         IRQ
);

  localparam int NUM_LANES = 4;

  // register state
  logic        en, ar, ie;
  logic [15:0] prescale;
  logic [15:0] pre_cnt;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;

  // decode
  logic sel, legal, misalign, err;
  logic wr, wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;

  assign sel = (bus.A[31:5] == BASE_ADDR[31:5]);

  // legal access codes and natural-alignment check
  always_comb begin
    legal    = (bus.size == 3'b000) || (bus.size == 3'b001) || (bus.size == 3'b010) ||
               (bus.size == 3'b100) || (bus.size == 3'b101);
    misalign = ((bus.size[1:0] == 2'b01) && bus.A[0]) ||
               ((bus.size[1:0] == 2'b10) && (bus.A[1:0] != 2'b00));
    err      = sel && (!legal || misalign);
  end

  assign bus.Sel = sel;
  assign bus.Err = err;

  assign wr          = bus.WE && sel && !err;
  assign wr_ctrl     = wr && (bus.A[4:2] == 3'd0);
  assign wr_prescale = wr && (bus.A[4:2] == 3'd1);
  assign wr_count    = wr && (bus.A[4:2] == 3'd2);
  assign wr_compare  = wr && (bus.A[4:2] == 3'd3);
  assign wr_status   = wr && (bus.A[4:2] == 3'd4);

  // read path: pick the register, then the byte/half lane, then extend
  logic [31:0] rdat, rd_ext;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // register select for loads
  always_comb begin
    rdat = '0;
    case (bus.A[4:2])
      3'd0:    rdat = {29'd0, ie, ar, en};
      3'd1:    rdat = {16'd0, prescale};
      3'd2:    rdat = count;
      3'd3:    rdat = compare;
      3'd4:    rdat = {31'd0, match};
      default: rdat = '0;
    endcase
  end

  // lane extraction and sign/zero extension
  always_comb begin
    rbyte = rdat[7:0];
    case (bus.A[1:0])
      2'd0: rbyte = rdat[7:0];
      2'd1: rbyte = rdat[15:8];
      2'd2: rbyte = rdat[23:16];
      2'd3: rbyte = rdat[31:24];
      default: rbyte = rdat[7:0];
    endcase
    rhalf = bus.A[1] ? rdat[31:16] : rdat[15:0];
    case (bus.size)
      3'b000:  rd_ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  rd_ext = {{16{rhalf[15]}}, rhalf};
      3'b010:  rd_ext = rdat;
      3'b100:  rd_ext = {24'd0, rbyte};
      3'b101:  rd_ext = {16'd0, rhalf};
      default: rd_ext = '0;
    endcase
    bus.RD = (sel && !err) ? rd_ext : 32'd0;
  end

  // write path: byte enables and store data replicated onto every lane
  logic [NUM_LANES-1:0] be;
  logic [31:0]          wlane;

  // lane enables from access size and low address bits
  always_comb begin
    be    = '0;
    wlane = bus.WD;
    case (bus.size[1:0])
      2'b00: begin
        be[bus.A[1:0]] = 1'b1;
        wlane          = {4{bus.WD[7:0]}};
      end
      2'b01: begin
        be    = bus.A[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.WD[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  logic [31:0] count_wv, compare_wv;
  logic [15:0] prescale_wv;
  logic [2:0]  ctrl_wv;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign count_wv[8*i +: 8]   = be[i] ? wlane[8*i +: 8] : count[8*i +: 8];
    assign compare_wv[8*i +: 8] = be[i] ? wlane[8*i +: 8] : compare[8*i +: 8];
  end

  assign prescale_wv = {be[1] ? wlane[15:8] : prescale[15:8],
                        be[0] ? wlane[7:0]  : prescale[7:0]};
  assign ctrl_wv     = be[0] ? wlane[2:0] : {ie, ar, en};

  // timing: a write clearing EN stops the timer on that very edge
  logic        en_next, run, tick, hit, st_clr;
  logic [31:0] count_inc;

  assign en_next   = wr_ctrl ? ctrl_wv[0] : en;
  assign run       = en && en_next;
  assign tick      = run && (pre_cnt == prescale);
  assign count_inc = count + 32'd1;
  // a CPU write to COUNT swallows the tick, so no match can be raised that edge
  assign hit       = tick && !wr_count && (count_inc == compare);
  assign st_clr    = wr_status && be[0] && wlane[0];

  // control register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)        {ie, ar, en} <= 3'b000;
    else if (wr_ctrl) {ie, ar, en} <= ctrl_wv;
  end

  // prescale value and prescale counter; any PRESCALE write restarts the period
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else begin
      if (wr_prescale) prescale <= prescale_wv;
      if (wr_prescale) pre_cnt  <= '0;
      else if (run)    pre_cnt  <= tick ? 16'd0 : pre_cnt + 16'd1;
    end
  end

  // main counter: CPU write beats tick; auto-reload to 0 on match
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)         count <= '0;
    else if (wr_count) count <= count_wv;
    else if (tick)     count <= (hit && ar) ? 32'd0 : count_inc;
  end

  // compare register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)           compare <= '0;
    else if (wr_compare) compare <= compare_wv;
  end

  // sticky match flag; a new match wins over a same-cycle W1C
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)       match <= 1'b0;
    else if (hit)    match <= 1'b1;
    else if (st_clr) match <= 1'b0;
  end

  assign IRQ = match && ie;

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever a checked access is on the bus.
module tb_mmio_timer;

  localparam logic [31:0] B = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset;
  logic irq;

  always #5 clk = ~clk;

  mmio_timer_if bus ();

  mmio_timer #(.BASE_ADDR(B)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQ   (irq)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        sel;
    logic        err;
    logic        irq;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  logic  chk = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: one checked access per cycle, sampled on the falling edge
  exp_t  e;
  string enm;
  always @(negedge clk) begin
    if (chk) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: got access with no expectation");
      end else begin
        e   = q.pop_front();
        enm = nq.pop_front();
        cmp({enm, ".RD"},  bus.RD,         e.rd);
        cmp({enm, ".Sel"}, {31'd0, bus.Sel}, {31'd0, e.sel});
        cmp({enm, ".Err"}, {31'd0, bus.Err}, {31'd0, e.err});
        cmp({enm, ".IRQ"}, {31'd0, irq},     {31'd0, e.irq});
      end
    end
  end

  task automatic op(input logic we, input logic [31:0] a, input logic [2:0] sz,
                    input logic [31:0] wd, input logic chk_en, input logic [31:0] x_rd,
                    input logic x_sel, input logic x_err, input logic x_irq, input string nm);
    @(posedge clk);
    #1;
    bus.WE   = we;
    bus.A    = a;
    bus.size = sz;
    bus.WD   = wd;
    chk      = chk_en;
    if (chk_en) begin
      q.push_back('{rd: x_rd, sel: x_sel, err: x_err, irq: x_irq});
      nq.push_back(nm);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    op(1'b1, a, sz, wd, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] x,
                    input logic x_irq, input string nm);
    op(1'b0, a, sz, 32'd0, 1'b1, x, 1'b1, 1'b0, x_irq, nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      op(1'b0, B + 32'h14, 3'b010, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "");
  endtask

  initial begin
    reset    = 1'b1;
    bus.WE   = 1'b0;
    bus.A    = B;
    bus.size = 3'b010;
    bus.WD   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    rd(B + 32'h00, 3'b010, 32'd0, 1'b0, "rst_ctrl");
    rd(B + 32'h04, 3'b010, 32'd0, 1'b0, "rst_prescale");
    rd(B + 32'h08, 3'b010, 32'd0, 1'b0, "rst_count");
    rd(B + 32'h0C, 3'b010, 32'd0, 1'b0, "rst_compare");
    rd(B + 32'h10, 3'b010, 32'd0, 1'b0, "rst_status");
    op(1'b0, B + 32'h20, 3'b010, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, "unsel");

    // prescaled count with auto-reload; CTRL write commits on edge 0
    wr(B + 32'h04, 3'b010, 32'd3);
    wr(B + 32'h0C, 3'b010, 32'd5);
    wr(B + 32'h00, 3'b010, 32'h7);
    idle(4);                                              // edges 0..3
    rd(B + 32'h08, 3'b010, 32'd1, 1'b0, "ps_cnt_e4");     // edge 4
    idle(14);                                             // edges 5..18
    rd(B + 32'h08, 3'b010, 32'd4, 1'b0, "ps_cnt_e19");
    rd(B + 32'h08, 3'b010, 32'd0, 1'b1, "ps_reload_e20");
    rd(B + 32'h10, 3'b010, 32'd1, 1'b1, "ps_match_e21");
    wr(B + 32'h10, 3'b010, 32'd1);
    rd(B + 32'h10, 3'b010, 32'd0, 1'b0, "w1c_clear");
    wr(B + 32'h00, 3'b010, 32'd0);

    // wrap through 0xFFFF_FFFF with COMPARE=0, AR=0
    wr(B + 32'h08, 3'b010, 32'hFFFF_FFFE);
    wr(B + 32'h04, 3'b010, 32'd0);
    wr(B + 32'h0C, 3'b010, 32'd0);
    wr(B + 32'h00, 3'b010, 32'd1);
    rd(B + 32'h08, 3'b010, 32'hFFFF_FFFE, 1'b0, "wrap_e0");
    rd(B + 32'h08, 3'b010, 32'hFFFF_FFFF, 1'b0, "wrap_e1");
    rd(B + 32'h08, 3'b010, 32'h0000_0000, 1'b0, "wrap_e2");
    rd(B + 32'h10, 3'b010, 32'd1, 1'b0, "wrap_match");
    wr(B + 32'h00, 3'b010, 32'd0);
    wr(B + 32'h10, 3'b010, 32'd1);

    // byte lane store and extended loads
    wr(B + 32'h08, 3'b010, 32'd0);
    wr(B + 32'h09, 3'b000, 32'h0000_0080);
    rd(B + 32'h08, 3'b010, 32'h0000_8000, 1'b0, "sb_lw");
    rd(B + 32'h09, 3'b000, 32'hFFFF_FF80, 1'b0, "sb_lb");
    rd(B + 32'h09, 3'b100, 32'h0000_0080, 1'b0, "sb_lbu");
    rd(B + 32'h08, 3'b001, 32'hFFFF_8000, 1'b0, "sb_lh");
    rd(B + 32'h0A, 3'b101, 32'h0000_0000, 1'b0, "sb_lhu_hi");

    // misaligned / illegal accesses
    wr(B + 32'h0C, 3'b010, 32'h1234_5678);
    op(1'b1, B + 32'h0D, 3'b001, 32'h0000_BEEF, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, "sh_misalign");
    rd(B + 32'h0C, 3'b010, 32'h1234_5678, 1'b0, "cmp_unchanged");
    op(1'b0, B + 32'h0E, 3'b010, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, "lw_misalign");
    op(1'b0, B + 32'h00, 3'b011, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, "size_illegal");
    rd(B + 32'h14, 3'b010, 32'd0, 1'b0, "reserved_reg");

    // W1C in the same cycle as a new match: set wins
    wr(B + 32'h0C, 3'b010, 32'd3);
    wr(B + 32'h08, 3'b010, 32'd0);
    wr(B + 32'h00, 3'b010, 32'h5);                        // EN+IE, commits E0
    idle(2);                                              // E0, E1
    wr(B + 32'h10, 3'b010, 32'd1);                        // commits on match edge E3
    rd(B + 32'h10, 3'b010, 32'd1, 1'b1, "w1c_vs_match");
    rd(B + 32'h08, 3'b010, 32'd4, 1'b1, "run_e4");

    // COUNT write during a tick cycle wins over the tick
    wr(B + 32'h08, 3'b010, 32'h0000_0100);
    rd(B + 32'h08, 3'b010, 32'h0000_0100, 1'b1, "cnt_wr_wins");
    rd(B + 32'h08, 3'b010, 32'h0000_0101, 1'b1, "cnt_after_wr");

    // asynchronous reset mid-count
    @(posedge clk);
    #1;
    reset    = 1'b1;
    bus.WE   = 1'b0;
    bus.A    = B + 32'h08;
    bus.size = 3'b010;
    chk      = 1'b1;
    q.push_back('{rd: 32'd0, sel: 1'b1, err: 1'b0, irq: 1'b0});
    nq.push_back("async_rst_count");
    @(posedge clk);
    #1 reset = 1'b0;
    chk = 1'b0;
    rd(B + 32'h00, 3'b010, 32'd0, 1'b0, "post_rst_ctrl");
    rd(B + 32'h08, 3'b010, 32'd0, 1'b0, "post_rst_count");

    idle(2);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer peripheral that sits on the CPU data bus beside `DM` and answers the same load/store interface the CPU drives: `WE`, `size`, `A`, `WD` in, `RD` out. It holds a prescaled 32-bit up-counter, a compare register and a sticky match flag, and raises an interrupt line. Reads are combinational so the single-cycle CPU completes loads in one cycle. Writes commit on the rising edge of `CLK`.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h0000_1000: base of the 32-byte register window; must be 32-byte aligned.

Ports:
- `CLK` input, 1 bit: single system clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state immediately.
- `WE` input, 1 bit: store strobe from the CPU.
- `size` input, 3 bits: RISC-V funct3 access code.
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Other codes are illegal.
- `A` input, 32 bits: byte address.
- `WD` input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
- `RD` output, 32 bits: load data, extended per `size`.
- `Sel` output, 1 bit: `A[31:5] == BASE_ADDR[31:5]`; the bus mux uses it to choose `RD` over `DM`.
- `Err` output, 1 bit: `Sel` and (misaligned or illegal `size`).
- `IRQ` output, 1 bit: `STATUS.MATCH & CTRL.IE`.

## Operation

- Register map, offset `A[4:0]`:
  - 0x00 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE; other bits read 0.
  - 0x04 PRESCALE: bits [15:0]; upper bits read 0.
  - 0x08 COUNT: bits [31:0].
  - 0x0C COMPARE: bits [31:0].
  - 0x10 STATUS: bit0 MATCH, write-1-to-clear.
  - 0x14–0x1F: read 0, writes ignored.
- Alignment rules:
  - Half access requires `A[0]=0`; word access requires `A[1:0]=0`.
  - Misaligned or illegal access: `Err=1`, `RD=0`, write suppressed.
- Loads:
  - Select the byte/half lane from `A[1:0]` of the addressed 32-bit register.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - `RD=0` whenever `Sel=0`.
- Stores (`WE & Sel & !Err`): update only the addressed byte lanes; other lanes hold.
- Prescaler: internal 16-bit `pre_cnt`. While EN=1:
  - If `pre_cnt == PRESCALE`, assert `tick` and set `pre_cnt <= 0`.
  - Otherwise `pre_cnt <= pre_cnt + 1`.
- Tick handling, with `next = COUNT + 1` (mod 2^32, so 0xFFFF_FFFF wraps to 0):
  - If `next == COMPARE`: set MATCH; COUNT loads 0 when AR=1, else `next`.
  - Otherwise COUNT loads `next`.
- EN=0: `pre_cnt` and COUNT hold; MATCH holds.
- Priority rules:
  - A CPU write to COUNT in a tick cycle wins; that tick is discarded and no match is evaluated.
  - Any write to PRESCALE clears `pre_cnt` to 0.
  - STATUS W1C and a new match in the same cycle: MATCH stays 1 (set wins).
  - A write clearing EN takes effect on that edge; no tick is processed that edge.
- COMPARE=0 with AR=0 matches on the wrap from 0xFFFF_FFFF to 0.

## Timing

- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=0, MATCH=0, `pre_cnt`=0, `IRQ`=0.
- `RD`, `Sel` and `Err` are combinational from the inputs (plus `RD` from register state).
- Reset asserted mid-count clears everything asynchronously, with no wait for `CLK`.
- Load latency: 0 cycles; `RD` is valid in the same cycle `A` is presented.
- Store latency: visible to a load in the cycle after the write edge.
- Tick period: PRESCALE+1 cycles. COUNT changes on the edge where `pre_cnt == PRESCALE`.
- MATCH and `IRQ` rise on the same edge that COUNT reaches COMPARE (or reloads to 0).
- A W1C on STATUS drops `IRQ` on the write edge.
- Set EN=1 on edge 0 with PRESCALE=0: COUNT is 1 after edge 1.

## Test plan

- Reset, then LW at 0x00, 0x04, 0x08, 0x0C, 0x10 -> all read 0. `IRQ=0`. `Sel=1`. A load at BASE+0x20 gives `Sel=0`, `RD=0`.
- PRESCALE=3, COMPARE=5, CTRL=0b111 -> COUNT advances every 4 cycles. MATCH and `IRQ` rise on the 20th edge after enable, with COUNT=0. SW 1 to STATUS -> `IRQ=0` next cycle.
- SW 0xFFFF_FFFE to COUNT, CTRL=1, PRESCALE=0, COMPARE=0 -> COUNT goes 0xFFFF_FFFF, then 0. MATCH sets on the wrap edge.
- SB 0x80 to BASE+0x09 after SW 0 to COUNT -> LW reads 0x0000_8000, LB at 0x09 reads 0xFFFF_FF80, LBU reads 0x0000_0080.
- SH to BASE+0x0D and LW at BASE+0x0E -> `Err=1`, `RD=0`, COMPARE unchanged. `size=3'b011` at BASE -> `Err=1`.
- Force W1C on STATUS in the same cycle as a match -> MATCH remains 1. Write COUNT in a tick cycle -> COUNT equals the written value. Pulse `reset` mid-count -> COUNT=0 immediately, before the next `CLK` edge.
